// File: rtl/cam_src_pkg.sv
// Shared types and encodings for the camera pattern source.
package cam_src_pkg;

  localparam int PIX_W = 12;
  localparam int CNT_W = 16;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STROBE,
    ST_V_FRONT,
    ST_LINE,
    ST_H_BLANK,
    ST_V_BACK
  } state_t;

  localparam logic [1:0] PAT_SOLID = 2'd0;
  localparam logic [1:0] PAT_HRAMP = 2'd1;
  localparam logic [1:0] PAT_VRAMP = 2'd2;
  localparam logic [1:0] PAT_COUNT = 2'd3;

endpackage

// File: rtl/cam_src_pattern.sv
// Combinational pixel value generator for the latched frame pattern.
module cam_src_pattern
  import cam_src_pkg::*;
(
  input  logic [1:0] i_pattern,
  input  pix_t       i_value,
  input  pix_t       i_col,
  input  pix_t       i_row,
  input  pix_t       i_count,
  output pix_t       o_pix
);

  always_comb begin
    // NOTE: default first so every path assigns o_pix and no latch is inferred.
    o_pix = i_value;
    case (i_pattern)
      PAT_HRAMP: o_pix = i_col;
      PAT_VRAMP: o_pix = i_row;
      PAT_COUNT: o_pix = i_count;
      default:   o_pix = i_value;
    endcase
  end

endmodule

// File: rtl/camera_pattern_source.sv
// Camera-sensor emulator: plays one synthetic frame per accepted trigger.
// Optional frame checksum output enabled by defining CAM_SRC_FRAME_SUM_EN.
module camera_pattern_source
  import cam_src_pkg::*;
#(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int H_BLANK      = 16,
  parameter int V_FRONT      = 8,
  parameter int V_BACK       = 8,
  parameter int STROBE_TICKS = 4
) (
  input  logic             sysClk,
  input  logic             hard_reset,
  input  logic             trigger,
  input  logic [1:0]       pattern_sel,
  input  logic [PIX_W-1:0] frame_value,
  output logic             pixel_clk,
  output logic             FV,
  output logic             LV,
  output logic [PIX_W-1:0] pixel_data,
  output logic             Strobe,
  output logic             busy,
  output logic             frame_done,
  output logic             trigger_dropped
`ifdef CAM_SRC_FRAME_SUM_EN
  ,
  output logic [15:0]      frame_sum
`endif
);

  logic       r_pclk;
  state_t     r_state;
  cnt_t       r_cnt;
  cnt_t       r_row;
  logic [1:0] r_pat;
  pix_t       r_value;
  pix_t       r_pcnt;
  logic       r_done;
  logic       r_drop;
  logic       w_tick;
  logic       w_busy;
  pix_t       w_pix;

  assign w_tick = r_pclk;
  assign w_busy = (r_state != ST_IDLE);

  cam_src_pattern u_pattern (
    .i_pattern (r_pat),
    .i_value   (r_value),
    .i_col     (r_cnt[PIX_W-1:0]),
    .i_row     (r_row[PIX_W-1:0]),
    .i_count   (r_pcnt),
    .o_pix     (w_pix)
  );

  // State and counters advance only on ticks, so bus outputs move with pixel_clk's fall.
  always_ff @(posedge sysClk) begin
    if (hard_reset) begin
      r_pclk  <= 1'b0;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_row   <= '0;
      r_pat   <= PAT_SOLID;
      r_value <= '0;
      r_pcnt  <= '0;
      r_done  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register sees pre-edge values of the others.
      r_pclk <= ~r_pclk;
      r_done <= 1'b0;
      r_drop <= trigger && w_busy;
      if (w_tick) begin
        r_cnt <= r_cnt + cnt_t'(1);
        case (r_state)
          ST_IDLE: begin
            r_cnt <= '0;
            if (trigger) begin
              r_state <= ST_STROBE;
              r_pat   <= pattern_sel;
              r_value <= frame_value;
              r_pcnt  <= frame_value;
              r_row   <= '0;
            end
          end
          ST_STROBE: if (r_cnt == cnt_t'(STROBE_TICKS - 1)) begin
            r_cnt   <= '0;
            r_state <= (V_FRONT > 0) ? ST_V_FRONT : ST_LINE;
          end
          ST_V_FRONT: if (r_cnt == cnt_t'(V_FRONT - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_LINE;
          end
          ST_LINE: begin
            r_pcnt <= r_pcnt + pix_t'(1);
            if (r_cnt == cnt_t'(H_ACTIVE - 1)) begin
              r_cnt <= '0;
              if (r_row == cnt_t'(V_ACTIVE - 1)) begin
                if (V_BACK > 0) begin
                  r_state <= ST_V_BACK;
                end else begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
                end
              end else if (H_BLANK > 0) begin
                r_state <= ST_H_BLANK;
              end else begin
                r_row <= r_row + cnt_t'(1);
              end
            end
          end
          ST_H_BLANK: if (r_cnt == cnt_t'(H_BLANK - 1)) begin
            r_cnt   <= '0;
            r_row   <= r_row + cnt_t'(1);
            r_state <= ST_LINE;
          end
          ST_V_BACK: if (r_cnt == cnt_t'(V_BACK - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
          default: begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign pixel_clk       = r_pclk;
  assign Strobe          = (r_state == ST_STROBE);
  assign FV              = (r_state == ST_V_FRONT) || (r_state == ST_LINE) ||
                           (r_state == ST_H_BLANK) || (r_state == ST_V_BACK);
  assign LV              = (r_state == ST_LINE);
  assign pixel_data      = LV ? w_pix : '0;
  assign busy            = w_busy;
  assign frame_done      = r_done;
  assign trigger_dropped = r_drop;

`ifdef CAM_SRC_FRAME_SUM_EN
  logic [15:0] r_sum;

  // Cleared on frame start, held after the last active pixel until the next start.
  always_ff @(posedge sysClk) begin
    if (hard_reset) begin
      r_sum <= '0;
    end else if (w_tick) begin
      if (r_state == ST_IDLE && trigger) begin
        r_sum <= '0;
      end else if (r_state == ST_LINE) begin
        r_sum <= r_sum + 16'(w_pix);
      end
    end
  end

  assign frame_sum = r_sum;
`endif

endmodule

// File: tb/tb_camera_pattern_source.sv
// Randomized self-checking bench for camera_pattern_source with a per-tick frame model.
module tb_camera_pattern_source;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int HB = 2;
  localparam int VF = 1;
  localparam int VB = 1;
  localparam int ST = 2;
  localparam int FRAME_TICKS = ST + VF + V * H + (V - 1) * HB + VB;

  logic        sysClk = 1'b0;
  logic        hard_reset;
  logic        trigger;
  logic [1:0]  pattern_sel;
  logic [11:0] frame_value;
  logic        pixel_clk, FV, LV, Strobe, busy, frame_done, trigger_dropped;
  logic [11:0] pixel_data;
`ifdef CAM_SRC_FRAME_SUM_EN
  logic [15:0] frame_sum;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int   exp_sum;
  logic mon_en = 1'b0;
  logic prev_pclk;
  logic [14:0] prev_bus;

  camera_pattern_source #(
    .H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB),
    .V_FRONT(VF), .V_BACK(VB), .STROBE_TICKS(ST)
  ) dut (
    .sysClk          (sysClk),
    .hard_reset      (hard_reset),
    .trigger         (trigger),
    .pattern_sel     (pattern_sel),
    .frame_value     (frame_value),
    .pixel_clk       (pixel_clk),
    .FV              (FV),
    .LV              (LV),
    .pixel_data      (pixel_data),
    .Strobe          (Strobe),
    .busy            (busy),
    .frame_done      (frame_done),
    .trigger_dropped (trigger_dropped)
`ifdef CAM_SRC_FRAME_SUM_EN
    ,
    .frame_sum       (frame_sum)
`endif
  );

  always #5 sysClk = ~sysClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bus must be stable across each pixel_clk rise and blank whenever LV is low.
  always @(negedge sysClk) begin
    if (mon_en) begin
      if (!prev_pclk && pixel_clk)
        check("edge_stable", {Strobe, FV, LV, pixel_data}, prev_bus);
      if (!LV)
        check("blank_zero", pixel_data, 0);
    end
    prev_pclk <= pixel_clk;
    prev_bus  <= {Strobe, FV, LV, pixel_data};
  end

  // Expected per-tick {Strobe, FV, LV, busy, data} sequence from the frame rules.
  task automatic build_expect(input int pat, input int val);
    int pix;
    exp_q.delete();
    exp_sum = 0;
    for (int i = 0; i < ST; i++) exp_q.push_back({4'b1001, 12'h000});
    for (int i = 0; i < VF; i++) exp_q.push_back({4'b0101, 12'h000});
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
        case (pat)
          0:       pix = val;
          1:       pix = c % 4096;
          2:       pix = r % 4096;
          default: pix = (val + r * H + c) % 4096;
        endcase
        exp_sum = (exp_sum + pix) % 65536;
        exp_q.push_back({4'b0111, 12'(pix)});
      end
      if (r < V - 1)
        for (int i = 0; i < HB; i++) exp_q.push_back({4'b0101, 12'h000});
    end
    for (int i = 0; i < VB; i++) exp_q.push_back({4'b0101, 12'h000});
  endtask

  task automatic run_frame(input int pat, input int val, input bit scramble,
                           input bit drop, input bit hold);
    int  lat = 0;
    int  busy_cnt = 0, drop_cnt = 0, done_cnt = 0;
    bit  pulsed = 0;
    logic prev_fv = 1'b0;
    build_expect(pat, val);
    got_q.delete();
    pattern_sel = 2'(pat);
    frame_value = 12'(val);
    trigger     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sysClk);
      lat++;
      if (Strobe) break;
    end
    check("start_latency", {31'd0, Strobe && lat <= 2}, 1);
    if (!hold) trigger = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy) busy_cnt++;
      if (busy && pixel_clk) got_q.push_back({Strobe, FV, LV, busy, pixel_data});
      if (trigger_dropped && !hold) drop_cnt++;
      if (pulsed && !hold) trigger = 1'b0;
      if (drop && !pulsed && LV) begin
        trigger = 1'b1;
        pulsed  = 1'b1;
      end
      if (scramble && i == 7) begin
        pattern_sel = 2'($urandom);
        frame_value = 12'($urandom);
      end
      if (frame_done) begin
        done_cnt++;
        check("done_after_fv_fall", {prev_fv, FV, busy}, 3'b100);
        break;
      end
      prev_fv = FV;
      @(negedge sysClk);
    end
    check("frame_done_count", done_cnt, 1);
    check("busy_cycles", busy_cnt, 2 * FRAME_TICKS);
    check("drop_count", drop_cnt, (drop && !hold) ? 1 : 0);
    check("tick_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("tick%0d_p%0d", i, pat), got_q[i], exp_q[i]);
`ifdef CAM_SRC_FRAME_SUM_EN
    check("frame_sum", frame_sum, exp_sum);
`endif
    @(negedge sysClk);
    if (hold) begin
      check("hold_idle_tick", {busy, Strobe}, 2'b00);
      @(negedge sysClk);
      check("hold_restart", Strobe, 1);
      trigger = 1'b0;
      for (int i = 0; i < 200 && !frame_done; i++) @(negedge sysClk);
      check("hold_second_done", frame_done, 1);
      @(negedge sysClk);
    end else begin
      check("done_pulse_width", frame_done, 0);
    end
  endtask

  task automatic reset_mid_frame();
    int lv_rises = 0;
    int dones = 0;
    logic prev_lv = 1'b0;
    pattern_sel = 2'd1;
    trigger     = 1'b1;
    for (int i = 0; i < 3 && !Strobe; i++) @(negedge sysClk);
    trigger = 1'b0;
    for (int i = 0; i < 100 && lv_rises < 2; i++) begin
      @(negedge sysClk);
      if (LV && !prev_lv) lv_rises++;
      prev_lv = LV;
    end
    check("reached_row1", lv_rises, 2);
    hard_reset = 1'b1;
    @(negedge sysClk);
    check("rst_outputs", {pixel_clk, FV, LV, Strobe, busy, frame_done, trigger_dropped, pixel_data}, 0);
`ifdef CAM_SRC_FRAME_SUM_EN
    check("rst_sum", frame_sum, 0);
`endif
    hard_reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sysClk);
      if (frame_done) dones++;
    end
    check("no_done_after_rst", dones, 0);
    check("idle_after_rst", busy, 0);
  endtask

  initial begin
    int b;
    hard_reset  = 1'b1;
    trigger     = 1'b0;
    pattern_sel = 2'd0;
    frame_value = 12'd0;
    repeat (3) @(negedge sysClk);
    check("reset_state", {pixel_clk, FV, LV, Strobe, busy, frame_done, trigger_dropped, pixel_data}, 0);
    hard_reset = 1'b0;
    @(negedge sysClk);
    mon_en = 1'b1;
    b = pixel_clk;
    @(negedge sysClk);
    check("pclk_toggle", pixel_clk, ~b & 1);

    run_frame(1, 0, 0, 0, 0);
    run_frame(3, 'hFFE, 0, 0, 0);
    run_frame(2, int'($urandom_range(0, 4095)), 1, 0, 0);
    run_frame(0, 'hABC, 0, 1, 0);
    b = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge sysClk);
      if (busy) b++;
    end
    check("no_second_frame", b, 0);
    run_frame(3, 'h123, 0, 0, 1);
    reset_mid_frame();
    run_frame(3, 'hFFE, 0, 0, 0);

    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 5)) @(negedge sysClk);
      run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)),
                1'($urandom), 1'($urandom), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
